uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
- Buffered UART transmitter, 8N1, LSB first; the transmit-side counterpart of the program-load receiver.
- Sits between the CPU writeback stage (the `out` instruction path) and the board `txd` pin.
- Accepts bytes in single-cycle write pulses into a small FIFO and serializes them back-to-back without CPU stalls.
- Reports fill level and a sticky overflow flag so the CPU/top can throttle output.

Parameters:
- CLK_PER_HALF_BIT, 434, clocks per half UART bit; one bit period = 2*CLK_PER_HALF_BIT clocks.
- DEPTH_LOG2, 4, FIFO depth = 2**DEPTH_LOG2 entries (default 16).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- wdata  input  8  byte to enqueue.
- we  input  1  write strobe, one byte per cycle it is high.
- full  output  1  FIFO holds 2**DEPTH_LOG2 entries.
- count  output  DEPTH_LOG2+1  current FIFO occupancy, 0..2**DEPTH_LOG2.
- busy  output  1  high while a frame is on the line or FIFO non-empty.
- ovf  output  1  sticky: a write was dropped while full.
- ovf_clr  input  1  clears ovf.
- txd  output  1  serial line, idle high.

Behaviour:
- Reset (async, rst=1):
  - FIFO pointers and count = 0.
  - FSM enters IDLE; txd=1, busy=0, ovf=0, full=0.
  - Any frame in progress is aborted immediately and txd returns high.
- FIFO:
  - Circular buffer; read and write pointers are DEPTH_LOG2 bits and wrap modulo depth.
  - full and count are registered and reflect state after the last edge.
- Write rule:
  - we=1 with full=0: wdata stored at edge, count+1.
  - we=1 with full=1: byte dropped and ovf set at that edge, even if a pop occurs the same cycle.
- Simultaneous push and pop (not full): count unchanged; both pointers advance.
- ovf:
  - ovf_clr=1 clears ovf.
  - If ovf_clr and a dropped write coincide, set wins.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: txd=1. If count>0 at an edge, pop the head byte into the shift register, zero the bit timer, go START, and drive txd=0 from that edge.
  - START: txd=0 for 2*CLK_PER_HALF_BIT clocks, then go DATA with bit index 0.
  - DATA: txd=shift[0] for one bit period per bit, shifting right. After bit index 7 completes, go STOP.
  - STOP: txd=1 for one bit period.
    - At its last clock, if count>0: pop, go START directly (no idle gap).
    - Otherwise go IDLE.
- Bit timer:
  - Counts 0..2*CLK_PER_HALF_BIT-1.
  - Width is ceil(log2(2*CLK_PER_HALF_BIT)) bits and must not overflow.
- Timing:
  - Latency: we high at edge N into an empty, idle block → count=1 after N; pop at edge N+1; txd falls after edge N+1.
  - Frame length is exactly 10 bit periods = 20*CLK_PER_HALF_BIT clocks.
  - Back-to-back frames are contiguous.
- busy = (state != IDLE) | (count != 0).
- txd is driven from a flop, with no combinational path from inputs.

Test Plan:
- Single byte (CLK_PER_HALF_BIT=2): reset, write 0xAA once → after 2 edges txd low for 4 clocks, then bits 0,1,0,1,0,1,0,1 at 4 clocks each, stop high 4 clocks; busy falls after exactly 40 clocks of framing; count back to 0.
- Back-to-back: write 0x55, 0x0F, 0xF0 on consecutive cycles → count peaks at 2, then three 40-clock frames with no idle gap, decoded bytes 0x55, 0x0F, 0xF0 in order.
- Overflow (DEPTH_LOG2=2): write 6 bytes 0x01..0x06 in consecutive cycles → first byte popped, 0x02..0x05 buffered, full=1, 0x06 dropped, ovf=1; line emits 0x01..0x05. ovf_clr pulse → ovf=0.
- Wrap-around: with DEPTH_LOG2=2, stream 20 bytes 0x00..0x13 while keeping count<4 → all 20 emitted in order, pointers wrap correctly.
- Reset mid-frame: assert rst during DATA bit 3 of 0xC3 with 2 bytes queued → txd=1 immediately, count=0, busy=0. After release, no residual frame appears in 100 clocks.
- Push/pop collision: with count=1 and the FSM at last STOP clock, assert we with 0x7E → count stays 1, next frame starts, and 0x7E is sent after it.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a small circular FIFO feeding a frame serializer
// that chains queued bytes back-to-back with no idle gap between frames.
module uart_tx_fifo #(
    parameter int CLK_PER_HALF_BIT = 434,
    parameter int DEPTH_LOG2       = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            wdata,
    input  logic                  we,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  busy,
    output logic                  ovf,
    input  logic                  ovf_clr,
    output logic                  txd
);

    localparam int BIT_CLKS = 2 * CLK_PER_HALF_BIT;
    localparam int TW       = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
    localparam int DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [TW-1:0]       TIMER_LAST = TW'(BIT_CLKS - 1);
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT  = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    logic [7:0]            mem_r [DEPTH];
    logic [DEPTH_LOG2-1:0] wptr_r;
    logic [DEPTH_LOG2-1:0] rptr_r;
    logic [DEPTH_LOG2:0]   count_r;
    logic [DEPTH_LOG2:0]   count_nxt_s;
    logic                  full_r;
    logic                  ovf_r;
    logic                  busy_r;
    logic                  txd_r;
    state_t                state_r;
    logic [TW-1:0]         timer_r;
    logic [2:0]            bit_idx_r;
    logic [7:0]            shift_r;
    logic                  push_s;
    logic                  pop_s;
    logic                  bit_end_s;
    logic                  active_nxt_s;

    assign push_s    = we & ~full_r;
    assign bit_end_s = (timer_r == TIMER_LAST);

    // Pop decision: IDLE launches as soon as data is queued, STOP chains on its last clock.
    always_comb begin
        pop_s = 1'b0;
        case (state_r)
            S_IDLE:  pop_s = (count_r != '0);
            S_STOP:  pop_s = bit_end_s & (count_r != '0);
            default: pop_s = 1'b0;
        endcase
    end

    // Next occupancy and next "frame active" flag, used to register full and busy.
    always_comb begin
        count_nxt_s  = count_r;
        active_nxt_s = 1'b0;
        if (push_s && !pop_s) begin
            count_nxt_s = count_r + (DEPTH_LOG2 + 1)'(1);
        end else if (!push_s && pop_s) begin
            count_nxt_s = count_r - (DEPTH_LOG2 + 1)'(1);
        end else begin
            count_nxt_s = count_r;
        end
        case (state_r)
            S_IDLE:  active_nxt_s = pop_s;
            S_START: active_nxt_s = 1'b1;
            S_DATA:  active_nxt_s = 1'b1;
            S_STOP:  active_nxt_s = ~bit_end_s | pop_s;
            default: active_nxt_s = 1'b0;
        endcase
    end

    // Storage array; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wptr_r] <= wdata;
        end
    end

    // FIFO pointers, occupancy and status flags. A dropped write wins over ovf_clr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_r  <= '0;
            rptr_r  <= '0;
            count_r <= '0;
            full_r  <= 1'b0;
            ovf_r   <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            if (push_s) begin
                wptr_r <= wptr_r + DEPTH_LOG2'(1);
            end
            if (pop_s) begin
                rptr_r <= rptr_r + DEPTH_LOG2'(1);
            end
            count_r <= count_nxt_s;
            full_r  <= (count_nxt_s == DEPTH_CNT);
            busy_r  <= active_nxt_s | (count_nxt_s != '0);
            if (we && full_r) begin
                ovf_r <= 1'b1;
            end else if (ovf_clr) begin
                ovf_r <= 1'b0;
            end
        end
    end

    // Frame serializer; txd is registered so the line never sees a combinational path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= S_IDLE;
            timer_r   <= '0;
            bit_idx_r <= 3'd0;
            shift_r   <= 8'h00;
            txd_r     <= 1'b1;
        end else begin
            case (state_r)
                S_IDLE: begin
                    txd_r <= 1'b1;
                    if (pop_s) begin
                        shift_r <= mem_r[rptr_r];
                        timer_r <= '0;
                        state_r <= S_START;
                        txd_r   <= 1'b0;
                    end
                end
                S_START: begin
                    if (bit_end_s) begin
                        timer_r   <= '0;
                        bit_idx_r <= 3'd0;
                        state_r   <= S_DATA;
                        txd_r     <= shift_r[0];
                    end else begin
                        timer_r <= timer_r + TW'(1);
                    end
                end
                S_DATA: begin
                    if (bit_end_s) begin
                        timer_r <= '0;
                        if (bit_idx_r == 3'd7) begin
                            state_r <= S_STOP;
                            txd_r   <= 1'b1;
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                            shift_r   <= {1'b0, shift_r[7:1]};
                            txd_r     <= shift_r[1];
                        end
                    end else begin
                        timer_r <= timer_r + TW'(1);
                    end
                end
                S_STOP: begin
                    if (bit_end_s) begin
                        timer_r <= '0;
                        if (pop_s) begin
                            shift_r <= mem_r[rptr_r];
                            state_r <= S_START;
                            txd_r   <= 1'b0;
                        end else begin
                            state_r <= S_IDLE;
                            txd_r   <= 1'b1;
                        end
                    end else begin
                        timer_r <= timer_r + TW'(1);
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                    txd_r   <= 1'b1;
                end
            endcase
        end
    end

    assign full  = full_r;
    assign count = count_r;
    assign busy  = busy_r;
    assign ovf   = ovf_r;
    assign txd   = txd_r;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with 4-clock bit periods and a 4-entry FIFO;
// every txd clock of every frame is compared against the expected 8N1 waveform.
module tb_uart_tx_fifo;

    logic       clk;
    logic       rst;
    logic [7:0] wdata;
    logic       we;
    logic       full;
    logic [2:0] count;
    logic       busy;
    logic       ovf;
    logic       ovf_clr;
    logic       txd;

    int n_tests;
    int n_fail;

    uart_tx_fifo #(.CLK_PER_HALF_BIT(2), .DEPTH_LOG2(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .wdata   (wdata),
        .we      (we),
        .full    (full),
        .count   (count),
        .busy    (busy),
        .ovf     (ovf),
        .ovf_clr (ovf_clr),
        .txd     (txd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare txd on every clock of one frame (k = clocks since the start edge),
    // optionally pulsing we for one edge at clock pk.
    task automatic frame_check(input logic [7:0] b, input int k0, input logic do_push,
                               input logic [7:0] pv, input int pk);
        logic [9:0] fr;
        fr = {1'b1, b, 1'b0};
        for (int k = k0; k < 40; k++) begin
            check($sformatf("frame_%02h_k%0d", b, k), {31'd0, txd}, {31'd0, fr[k/4]});
            if (do_push && k == pk) begin
                we    = 1'b1;
                wdata = pv;
            end
            step();
            if (do_push && k == pk) begin
                we = 1'b0;
            end
        end
    endtask

    task automatic write_byte(input logic [7:0] b);
        we    = 1'b1;
        wdata = b;
        step();
        we    = 1'b0;
    endtask

    initial begin
        logic any_low;
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        we      = 1'b0;
        wdata   = 8'h00;
        ovf_clr = 1'b0;
        step();
        step();
        check("rst_txd",   {31'd0, txd},  32'd1);
        check("rst_busy",  {31'd0, busy}, 32'd0);
        check("rst_count", {29'd0, count}, 32'd0);
        check("rst_full",  {31'd0, full}, 32'd0);
        check("rst_ovf",   {31'd0, ovf},  32'd0);
        rst = 1'b0;
        step();

        // Single byte: count=1 after write edge, txd falls one edge later.
        write_byte(8'hAA);
        check("single_count_n", {29'd0, count}, 32'd1);
        check("single_busy_n",  {31'd0, busy},  32'd1);
        check("single_txd_n",   {31'd0, txd},   32'd1);
        step();
        frame_check(8'hAA, 0, 1'b0, 8'h00, 0);
        check("single_busy_end",  {31'd0, busy},  32'd0);
        check("single_count_end", {29'd0, count}, 32'd0);
        check("single_txd_end",   {31'd0, txd},   32'd1);
        step();

        // Back-to-back: first byte popped on the second edge, count peaks at 2.
        we = 1'b1; wdata = 8'h55; step();
        check("b2b_count1", {29'd0, count}, 32'd1);
        wdata = 8'h0F; step();
        check("b2b_count2", {29'd0, count}, 32'd1);
        wdata = 8'hF0; step();
        we = 1'b0;
        check("b2b_count3", {29'd0, count}, 32'd2);
        frame_check(8'h55, 1, 1'b0, 8'h00, 0);
        frame_check(8'h0F, 0, 1'b0, 8'h00, 0);
        frame_check(8'hF0, 0, 1'b0, 8'h00, 0);
        check("b2b_busy_end", {31'd0, busy}, 32'd0);
        step();

        // Overflow: 0x01 popped, 0x02..0x05 fill the FIFO, 0x06 dropped.
        we = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            wdata = 8'(i);
            step();
            if (i == 5) begin
                check("ovf_full",     {31'd0, full},  32'd1);
                check("ovf_count4",   {29'd0, count}, 32'd4);
                check("ovf_pre_flag", {31'd0, ovf},   32'd0);
            end
        end
        we = 1'b0;
        check("ovf_flag",     {31'd0, ovf},   32'd1);
        check("ovf_count_dr", {29'd0, count}, 32'd4);
        frame_check(8'h01, 4, 1'b0, 8'h00, 0);
        for (int i = 2; i <= 5; i++) begin
            frame_check(8'(i), 0, 1'b0, 8'h00, 0);
        end
        check("ovf_busy_end", {31'd0, busy}, 32'd0);
        check("ovf_sticky",   {31'd0, ovf},  32'd1);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        check("ovf_cleared", {31'd0, ovf}, 32'd0);

        // Wrap-around: 20 bytes through a 4-entry FIFO, one refill per frame.
        we = 1'b1;
        wdata = 8'h00; step();
        wdata = 8'h01; step();
        wdata = 8'h02; step();
        we = 1'b0;
        for (int i = 0; i < 20; i++) begin
            frame_check(8'(i), (i == 0) ? 1 : 0, (i + 3 < 20), 8'(i + 3), 20);
        end
        check("wrap_busy_end",  {31'd0, busy},  32'd0);
        check("wrap_count_end", {29'd0, count}, 32'd0);
        step();

        // Push/pop collision on the last STOP clock keeps count at 1.
        we = 1'b1;
        wdata = 8'h11; step();
        wdata = 8'h22; step();
        we = 1'b0;
        check("coll_count_pre", {29'd0, count}, 32'd1);
        frame_check(8'h11, 0, 1'b1, 8'h7E, 39);
        check("coll_count", {29'd0, count}, 32'd1);
        frame_check(8'h22, 0, 1'b0, 8'h00, 0);
        frame_check(8'h7E, 0, 1'b0, 8'h00, 0);
        check("coll_busy_end", {31'd0, busy}, 32'd0);
        step();

        // Reset during DATA bit 3 of 0xC3 with two bytes queued.
        we = 1'b1;
        wdata = 8'hC3; step();
        wdata = 8'hAB; step();
        wdata = 8'hCD; step();
        we = 1'b0;
        check("rmid_count", {29'd0, count}, 32'd2);
        for (int k = 1; k < 17; k++) begin
            step();
        end
        check("rmid_bit3", {31'd0, txd}, 32'd0);
        rst = 1'b1;
        #1;
        check("rmid_txd",   {31'd0, txd},   32'd1);
        check("rmid_count0", {29'd0, count}, 32'd0);
        check("rmid_busy",  {31'd0, busy},  32'd0);
        #1;
        rst = 1'b0;
        any_low = 1'b0;
        for (int k = 0; k < 100; k++) begin
            step();
            if (txd !== 1'b1) any_low = 1'b1;
        end
        check("rmid_no_residual", {31'd0, any_low}, 32'd0);
        check("rmid_count_after", {29'd0, count},   32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
